// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win, long results queue in a FIFO.
// Optional perf counters under WB_PERF_EN.
module wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       lng_valid,
    output logic                       lng_ready,
    input  logic [4:0]                 lng_rd,
    input  logic [XLEN-1:0]            lng_data,
    output logic                       wen,
    output logic [4:0]                 wAddr,
    output logic [XLEN-1:0]            wData,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
    output logic                       alu_hold
`ifdef WB_PERF_EN
    ,
    output logic [31:0]                perf_alu_wr,
    output logic [31:0]                perf_lng_wr,
    output logic [31:0]                perf_conflict
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   starve;
    logic [SW-1:0]   starve_nxt;
    logic            push;
    logic            pop;
    logic            busy;

    assign busy      = (cnt != '0);
    assign lng_ready = (cnt < CW'(DEPTH));
    // rd==0 results are accepted but never stored
    assign push      = lng_valid && lng_ready && (lng_rd != 5'd0);
    assign pop       = !alu_valid && busy;
    assign fifo_cnt  = cnt;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) pend_mask[mem_rd[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_comb begin
        starve_nxt = starve;
        if (pop || !busy) begin
            starve_nxt = '0;
        end else if (alu_valid && starve != SW'(STARVE_MAX)) begin
            starve_nxt = starve + SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lng_rd;
            mem_data[wr_ptr] <= lng_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            starve   <= '0;
            alu_hold <= 1'b0;
            wen      <= 1'b0;
            wAddr    <= '0;
            wData    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (push && !pop) cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);

            starve   <= starve_nxt;
            alu_hold <= (starve_nxt == SW'(STARVE_MAX));

            if (alu_valid) begin
                wen   <= (alu_rd != 5'd0);
                wAddr <= alu_rd;
                wData <= alu_data;
            end else if (busy) begin
                wen   <= 1'b1;
                wAddr <= mem_rd[rd_ptr];
                wData <= mem_data[rd_ptr];
            end else begin
                wen   <= 1'b0;
            end
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_alu_wr   <= '0;
            perf_lng_wr   <= '0;
            perf_conflict <= '0;
        end else begin
            if (alu_valid && alu_rd != 5'd0) perf_alu_wr <= perf_alu_wr + 32'd1;
            if (pop) perf_lng_wr <= perf_lng_wr + 32'd1;
            if (alu_valid && busy) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule
